// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: reset vector,
// nop encoding and the fetch state encoding.
package if_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, talks to instruction memory with a req/ack
// handshake and fills IF/ID. Branch redirects honour one delay slot; flushes don't.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, restart_pc, redir_tgt, next_pc;
  logic [31:0]  skid_inst, skid_pc;
  logic         redir_pend;

  assign inst_req  = !reset && (state != HOLD);
  assign inst_addr = pc;
  assign if_id_pc8 = if_id_pc + 32'd8;

  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect_valid)  next_pc = redirect_pc;
    else if (redir_pend) next_pc = redir_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // An un-acked request cannot be withdrawn, so its result must be eaten.
      state_nxt = (state != HOLD && !inst_ack) ? DROP : FETCH;
    end else begin
      case (state)
        FETCH:   if (inst_ack && stall) state_nxt = HOLD;
        HOLD:    if (!stall) state_nxt = FETCH;
        DROP:    if (inst_ack) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      restart_pc  <= RESET_PC;
      redir_pend  <= 1'b0;
      redir_tgt   <= 32'h0;
      skid_inst   <= NOP;
      skid_pc     <= 32'h0;
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP;
      if_id_pc    <= 32'h0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP;
      redir_pend  <= 1'b0;
      // Outstanding request keeps pc on the bus; restart target waits aside.
      if (state != HOLD && !inst_ack) restart_pc <= flush_pc;
      else                            pc         <= flush_pc;
    end else begin
      case (state)
        FETCH: begin
          if (inst_ack) begin
            pc         <= next_pc;
            redir_pend <= 1'b0;
            if (stall) begin
              skid_inst <= inst_rdata;
              skid_pc   <= pc;
            end else begin
              if_id_valid <= 1'b1;
              if_id_inst  <= inst_rdata;
              if_id_pc    <= pc;
            end
          end else begin
            if (redirect_valid) begin
              redir_pend <= 1'b1;
              redir_tgt  <= redirect_pc;
            end
            if (!stall) begin
              if_id_valid <= 1'b0;
              if_id_inst  <= NOP;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_inst  <= skid_inst;
            if_id_pc    <= skid_pc;
          end
          if (redirect_valid) begin
            redir_pend <= 1'b1;
            redir_tgt  <= redirect_pc;
          end
        end
        DROP: begin
          // IF/ID is empty after a flush, so a redirect here has no owner.
          if (inst_ack) pc <= restart_pc;
        end
        default: ;
      endcase
    end
  end

endmodule
